// File: rtl/burst_trapper_pkg.sv
// Shared types and helpers for the burst_trapper read/write trapper.
// Imported by the top level and by the FIFO.
package burst_trapper_pkg;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Critical-word-first wrap; beats is a power of two, so masking is the modulo.
    function automatic logic [7:0] word_index(input logic [7:0] offset,
                                              input logic [7:0] k,
                                              input logic [7:0] beats);
        return (offset + k) & (beats - 8'd1);
    endfunction

endpackage

// File: rtl/trapper_fifo.sv
// Synchronous FIFO with a combinational head output.
// A push while full is dropped even if a pop happens in the same cycle.
module trapper_fifo
    import burst_trapper_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_SIZE-1:0]       din,
    output logic [DATA_SIZE-1:0]       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/burst_trapper.sv
// AXI4 read trapper: forwards AR requests to the monitor-bypass, returns buffered
// cache lines as wrapped bursts, and sinks writes with a one-outstanding AW/W/B handshake.
module burst_trapper
    import burst_trapper_pkg::*;
#(
    parameter int         C_S_AXI_ID_WIDTH   = 1,
    parameter int         C_S_AXI_DATA_WIDTH = 128,
    parameter int         C_S_AXI_ADDR_WIDTH = 40,
    parameter int         C_BRAM_DATA_WIDTH  = 512,
    parameter int         CHANNEL_ADDR_WIDTH = C_S_AXI_ADDR_WIDTH - 6,
    parameter int         QUEUE_LENGTH       = 8,
    parameter logic [1:0] WRITE_RESP         = 2'b00
) (
    input  logic                                        S_AXI_ACLK,
    input  logic                                        S_AXI_ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]                 S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_ARADDR,
    input  logic [7:0]                                  S_AXI_ARLEN,
    input  logic [2:0]                                  S_AXI_ARSIZE,
    input  logic [1:0]                                  S_AXI_ARBURST,
    input  logic                                        S_AXI_ARVALID,
    output logic                                        S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]                 S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_RDATA,
    output logic [1:0]                                  S_AXI_RRESP,
    output logic                                        S_AXI_RLAST,
    output logic                                        S_AXI_RVALID,
    input  logic                                        S_AXI_RREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]                 S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_AWADDR,
    input  logic [7:0]                                  S_AXI_AWLEN,
    input  logic                                        S_AXI_AWVALID,
    output logic                                        S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]             S_AXI_WSTRB,
    input  logic                                        S_AXI_WLAST,
    input  logic                                        S_AXI_WVALID,
    output logic                                        S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]                 S_AXI_BID,
    output logic [1:0]                                  S_AXI_BRESP,
    output logic                                        S_AXI_BVALID,
    input  logic                                        S_AXI_BREADY,
    output logic [CHANNEL_ADDR_WIDTH-1:0]               request_notification_addr,
    output logic [C_S_AXI_ID_WIDTH-1:0]                 request_notification_id,
    output logic [$clog2(C_BRAM_DATA_WIDTH/C_S_AXI_DATA_WIDTH)-1:0] request_notification_offset,
    output logic                                        request_notification_valid,
    input  logic [CHANNEL_ADDR_WIDTH-1:0]               availability_notification_addr,
    input  logic [C_S_AXI_ID_WIDTH-1:0]                 availability_notification_id,
    input  logic [$clog2(C_BRAM_DATA_WIDTH/C_S_AXI_DATA_WIDTH)-1:0] availability_notification_offset,
    input  logic [C_BRAM_DATA_WIDTH-1:0]                availability_notification_data,
    input  logic                                        availability_notification_valid,
    input  logic                                        monitor_bypass_ready,
    output logic                                        overflow_err,
    output logic                                        orphan_err,
    output logic                                        id_mismatch_err,
    output logic                                        read_state,
    output logic [1:0]                                  write_state
);

    localparam int IDW       = C_S_AXI_ID_WIDTH;
    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int BUS_BYTES = DW / 8;
    localparam int BEATS     = C_BRAM_DATA_WIDTH / DW;
    localparam int OW        = $clog2(BEATS);
    localparam int BUS_SHIFT = $clog2(BUS_BYTES);
    localparam int CW        = $clog2(QUEUE_LENGTH) + 1;
    localparam int LINE_W    = IDW + CHANNEL_ADDR_WIDTH + OW + C_BRAM_DATA_WIDTH;
    localparam int REQ_W     = IDW + 8;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic [LINE_W-1:0]             d_dout;
    logic                          d_full, d_empty;
    logic [CW-1:0]                 d_count;
    logic [REQ_W-1:0]              q_dout;
    logic                          q_full, q_empty;
    logic [CW-1:0]                 q_count;
    logic                          ar_hs, pop_both;
    logic [IDW-1:0]                d_id, q_id, bid_q;
    logic [CHANNEL_ADDR_WIDTH-1:0] d_addr;
    logic [OW-1:0]                 d_offset, widx;
    logic [C_BRAM_DATA_WIDTH-1:0]  d_data;
    logic [7:0]                    q_len, beat, len;
    logic [DW-1:0]                 line_words [BEATS];
    logic                          unused_sig;

    assign S_AXI_ARREADY = monitor_bypass_ready && !q_full && !S_AXI_ARESET;
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

    assign request_notification_valid  = ar_hs;
    assign request_notification_addr   = S_AXI_ARADDR[CHANNEL_ADDR_WIDTH+5:6];
    assign request_notification_offset = S_AXI_ARADDR[BUS_SHIFT +: OW];
    assign request_notification_id     = S_AXI_ARID;

    trapper_fifo #(.DATA_SIZE(LINE_W), .DEPTH(QUEUE_LENGTH)) u_line_fifo (
        .clk   (S_AXI_ACLK),
        .reset (S_AXI_ARESET),
        .push  (availability_notification_valid),
        .pop   (pop_both),
        .din   ({availability_notification_id, availability_notification_addr,
                 availability_notification_offset, availability_notification_data}),
        .dout  (d_dout),
        .full  (d_full),
        .empty (d_empty),
        .count (d_count)
    );

    trapper_fifo #(.DATA_SIZE(REQ_W), .DEPTH(QUEUE_LENGTH)) u_req_fifo (
        .clk   (S_AXI_ACLK),
        .reset (S_AXI_ARESET),
        .push  (ar_hs),
        .pop   (pop_both),
        .din   ({S_AXI_ARID, S_AXI_ARLEN}),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign {d_id, d_addr, d_offset, d_data} = d_dout;
    assign {q_id, q_len}                    = q_dout;

    // Word 0 sits in the most significant slice of the line.
    for (genvar w = 0; w < BEATS; w++) begin : g_words
        assign line_words[w] = d_data[(BEATS-1-w)*DW +: DW];
    end

    assign widx = OW'(word_index(8'(d_offset), beat, 8'(BEATS)));

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    always_comb begin
        r_next       = r_state;
        pop_both     = 1'b0;
        S_AXI_RVALID = 1'b0;
        S_AXI_RLAST  = 1'b0;
        S_AXI_RID    = '0;
        S_AXI_RDATA  = '0;
        S_AXI_RRESP  = RESP_OKAY;
        case (r_state)
            R_IDLE: begin
                if (!d_empty && !q_empty) begin
                    r_next = R_BURST;
                end
            end
            R_BURST: begin
                S_AXI_RVALID = 1'b1;
                S_AXI_RLAST  = (beat == len);
                S_AXI_RID    = q_id;
                S_AXI_RDATA  = line_words[widx];
                if (S_AXI_RREADY && (beat == len)) begin
                    pop_both = 1'b1;
                    r_next   = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next        = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = RESP_OKAY;
        case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = !S_AXI_ARESET;
                if (S_AXI_AWVALID) begin
                    w_next = W_DATA;
                end
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && S_AXI_WLAST) begin
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BRESP  = WRITE_RESP;
                if (S_AXI_BREADY) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign S_AXI_BID   = bid_q;
    assign read_state  = r_state;
    assign write_state = w_state;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            beat            <= '0;
            len             <= '0;
            bid_q           <= '0;
            overflow_err    <= 1'b0;
            orphan_err      <= 1'b0;
            id_mismatch_err <= 1'b0;
        end else begin
            if (r_state == R_IDLE && r_next == R_BURST) begin
                beat <= '0;
                len  <= q_len;
                if (d_id != q_id) begin
                    id_mismatch_err <= 1'b1;
                end
            end else if (r_state == R_BURST && S_AXI_RREADY && beat != len) begin
                beat <= beat + 8'd1;
            end
            if (w_state == W_IDLE && S_AXI_AWVALID) begin
                bid_q <= S_AXI_AWID;
            end
            if (availability_notification_valid && d_full) begin
                overflow_err <= 1'b1;
            end
            // A line arriving with no outstanding request to claim it.
            if (availability_notification_valid && (d_count >= q_count)) begin
                orphan_err <= 1'b1;
            end
        end
    end

    assign unused_sig = ^{S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_AWADDR, S_AXI_AWLEN,
                          S_AXI_WDATA, S_AXI_WSTRB, d_addr};

endmodule

// File: tb/tb_burst_trapper.sv
// Directed bench for burst_trapper: expected R beats go into a queue when stimulus
// is issued, and a negedge monitor compares every presented beat against the queue head.
module tb_burst_trapper;
    import burst_trapper_pkg::*;

    localparam int IDW = 1, DW = 128, AW = 40, LW = 512, CAW = 34, BEATS = 4, OW = 2;
    localparam int EW  = IDW + 1 + DW;
    localparam logic [1:0] WR_RESP = 2'b00;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [IDW-1:0]  arid = '0, rid, awid = '0, bid, req_id, av_id = '0;
    logic [AW-1:0]   araddr = '0, awaddr = '0;
    logic [7:0]      arlen = '0, awlen = '0;
    logic [2:0]      arsize = 3'd4;
    logic [1:0]      arburst = 2'b10, rresp, bresp;
    logic            arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b1;
    logic [DW-1:0]   rdata, wdata = '0;
    logic [DW/8-1:0] wstrb = '1;
    logic            awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic            bvalid, bready = 1'b0;
    logic [CAW-1:0]  req_addr, av_addr = '0;
    logic [OW-1:0]   req_offset, av_offset = '0;
    logic            req_valid, av_valid = 1'b0, mb_ready = 1'b1;
    logic [LW-1:0]   av_data = '0;
    logic            overflow_err, orphan_err, id_mismatch_err, read_state;
    logic [1:0]      write_state;

    logic [EW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    burst_trapper dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(reset),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .request_notification_addr(req_addr), .request_notification_id(req_id),
        .request_notification_offset(req_offset), .request_notification_valid(req_valid),
        .availability_notification_addr(av_addr), .availability_notification_id(av_id),
        .availability_notification_offset(av_offset), .availability_notification_data(av_data),
        .availability_notification_valid(av_valid),
        .monitor_bypass_ready(mb_ready),
        .overflow_err(overflow_err), .orphan_err(orphan_err), .id_mismatch_err(id_mismatch_err),
        .read_state(read_state), .write_state(write_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input logic [31:0] base, input int w);
        return {4{base + 32'(w)}};
    endfunction

    function automatic logic [LW-1:0] line_of(input logic [31:0] base);
        return {word_of(base, 0), word_of(base, 1), word_of(base, 2), word_of(base, 3)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats: word (offset+k) mod BEATS, RLAST on k == len.
    task automatic expect_burst(input logic [IDW-1:0] id, input int offset, input int len,
                                input logic [31:0] base);
        for (int k = 0; k <= len; k++) begin
            exp_q.push_back({id, (k == len), word_of(base, (offset + k) % BEATS)});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [CAW-1:0] exp_addr, input logic [OW-1:0] exp_off);
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) break;
        end
        check("ar_ready", arready, 1'b1);
        check("notif_valid", req_valid, 1'b1);
        check("notif_addr", req_addr, exp_addr);
        check("notif_offset", req_offset, exp_off);
        check("notif_id", req_id, id);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic push_avail(input logic [IDW-1:0] id, input logic [OW-1:0] off,
                              input logic [31:0] base);
        av_id = id; av_addr = CAW'(base); av_offset = off; av_data = line_of(base);
        av_valid = 1'b1;
        tick();
        av_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rvalid) break;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_beat: unexpected beat rid=%h rlast=%b rdata=%h at %0t",
                             rid, rlast, rdata, $time);
                end else begin
                    check("r_beat", {rid, rlast, rdata}, exp_q[0]);
                    check("r_resp", rresp, RESP_OKAY);
                    if (rready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int pat[8] = '{1, 0, 0, 1, 0, 0, 1, 1};
    int exp_rv[6] = '{1, 1, 0, 1, 1, 0};

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", arready, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_rid_rdata", {rid, rdata}, '0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_bid_bresp", {bid, bresp}, '0);
        check("rst_aw_w_ready", {awready, wready}, 2'b00);
        check("rst_errs", {overflow_err, orphan_err, id_mismatch_err}, 3'b000);
        check("rst_notif_valid", req_valid, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // basic burst, offset 2, with first-RVALID latency
        do_ar(1'b1, 40'h1020, 8'd3, 34'h40, 2'd2);
        expect_burst(1'b1, 2, 3, 32'h1000_0000);
        push_avail(1'b1, 2'd2, 32'h1000_0000);
        @(negedge clk);
        check("lat_cycle1", rvalid, 1'b0);
        @(negedge clk);
        check("lat_cycle2", rvalid, 1'b1);
        drain("drain_basic");

        // single beat at offset 3; ARLEN 7 wrapping twice
        do_ar(1'b0, 40'h2030, 8'd0, 34'h80, 2'd3);
        expect_burst(1'b0, 3, 0, 32'h2000_0000);
        push_avail(1'b0, 2'd3, 32'h2000_0000);
        drain("drain_len0");
        do_ar(1'b1, 40'h3000, 8'd7, 34'hC0, 2'd0);
        expect_burst(1'b1, 0, 7, 32'h3000_0000);
        push_avail(1'b1, 2'd0, 32'h3000_0000);
        drain("drain_len7");

        // RREADY stalls mid-burst
        do_ar(1'b0, 40'h5020, 8'd3, 34'h140, 2'd2);
        expect_burst(1'b0, 2, 3, 32'h5000_0000);
        push_avail(1'b0, 2'd2, 32'h5000_0000);
        for (int i = 0; i < 8; i++) begin
            rready = pat[i][0];
            tick();
        end
        rready = 1'b1;
        drain("drain_stall");

        // back-to-back bursts: exactly one idle cycle between them
        do_ar(1'b1, 40'h4010, 8'd1, 34'h100, 2'd1);
        do_ar(1'b0, 40'h4050, 8'd1, 34'h101, 2'd1);
        expect_burst(1'b1, 1, 1, 32'h4000_0000);
        expect_burst(1'b0, 1, 1, 32'h4100_0000);
        push_avail(1'b1, 2'd1, 32'h4000_0000);
        push_avail(1'b0, 2'd1, 32'h4100_0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("b2b_rvalid_%0d", i), rvalid, exp_rv[i][0]);
        end
        drain("drain_b2b");

        // monitor-bypass back-pressure
        mb_ready = 1'b0;
        arvalid = 1'b1;
        @(negedge clk);
        check("mb_busy_arready", arready, 1'b0);
        check("mb_busy_notif", req_valid, 1'b0);
        tick();
        arvalid = 1'b0;
        mb_ready = 1'b1;

        // request FIFO fills at 8 outstanding
        for (int i = 0; i < 8; i++) begin
            do_ar(IDW'(i % 2), 40'h6000 + 40'(i * 64 + (i % 4) * 16), 8'd0,
                  34'h180 + 34'(i), OW'(i % 4));
        end
        arvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ar_full_stall", arready, 1'b0);
        end
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_burst(IDW'(i % 2), i % 4, 0, 32'h6000_0000 + 32'(i * 16));
            push_avail(IDW'(i % 2), OW'(i % 4), 32'h6000_0000 + 32'(i * 16));
        end
        drain("drain_eight");
        check("errs_clean", {overflow_err, orphan_err, id_mismatch_err}, 3'b000);

        // write sink with BREADY held low
        awid = 1'b1; awvalid = 1'b1;
        @(negedge clk);
        check("aw_ready_idle", awready, 1'b1);
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wlast = (i == 3);
            wdata = DW'(i);
            @(negedge clk);
            check("w_ready", wready, 1'b1);
            check("w_no_early_b", bvalid, 1'b0);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_hold", {bvalid, bid, bresp}, {1'b1, 1'b1, WR_RESP});
            check("aw_blocked", awready, 1'b0);
            tick();
        end
        awvalid = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        check("b_handshake", bvalid, 1'b1);
        tick();
        bready = 1'b0;
        @(negedge clk);
        check("b_done", {bvalid, awready}, 2'b01);

        // reset in the middle of a burst
        do_ar(1'b1, 40'h7000, 8'd7, 34'h1C0, 2'd0);
        expect_burst(1'b1, 0, 7, 32'h7000_0000);
        push_avail(1'b1, 2'd0, 32'h7000_0000);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid) break;
        end
        check("pre_rst_rvalid", rvalid, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        @(negedge clk);
        check("rst_abort_rvalid", {rvalid, rlast}, 2'b00);
        tick();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", {rvalid, arready}, 2'b01);
        end
        tick();
        do_ar(1'b0, 40'h8010, 8'd1, 34'h200, 2'd1);
        expect_burst(1'b0, 1, 1, 32'h8000_0000);
        push_avail(1'b0, 2'd1, 32'h8000_0000);
        drain("drain_post_rst");
        check("post_rst_orphan", orphan_err, 1'b0);

        // ID mismatch at the top of the address range: burst still returned
        do_ar(1'b0, 40'hFF_FFFF_FFF0, 8'd0, 34'h3_FFFF_FFFF, 2'd3);
        expect_burst(1'b0, 3, 0, 32'h9000_0000);
        push_avail(1'b1, 2'd3, 32'h9000_0000);
        drain("drain_mismatch");
        check("id_mismatch_set", id_mismatch_err, 1'b1);

        // orphan lines then overflow
        for (int i = 0; i < 9; i++) begin
            push_avail(1'b0, 2'd0, 32'hA000_0000 + 32'(i));
            @(negedge clk);
            check($sformatf("orphan_%0d", i), orphan_err, 1'b1);
            check($sformatf("overflow_%0d", i), overflow_err, (i == 8));
        end
        repeat (3) tick();
        @(negedge clk);
        check("errs_sticky", {overflow_err, orphan_err, rvalid}, 3'b110);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("rst_arready_again", arready, 1'b0);
        check("rst_errs_clear", {overflow_err, orphan_err, id_mismatch_err}, 3'b000);
        tick();
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/burst_trapper.md
# burst_trapper

Parametrised successor of the cache-side AXI4 read trapper. It accepts AXI4 read bursts from the host port and forwards each accepted request to the monitor-bypass as a request notification. It buffers cache-line availability notifications and returns each line as a burst whose length comes from the matching ARLEN, in critical-word-first wrap order. It also sinks writes with a correct, one-outstanding AW/W/B handshake.

## Interface
- C_S_AXI_ID_WIDTH, 1, AXI ID width
- C_S_AXI_DATA_WIDTH, 128, AXI data width (DW); localparam BUS_BYTES = DW/8
- C_S_AXI_ADDR_WIDTH, 40, AXI address width
- C_BRAM_DATA_WIDTH, 512, line width; localparam BEATS = C_BRAM_DATA_WIDTH/DW, power of two, ≥ 2
- CHANNEL_ADDR_WIDTH, C_S_AXI_ADDR_WIDTH-6, line-address width
- QUEUE_LENGTH, 8, depth of the line-data FIFO and of the pending-request FIFO (power of two)
- WRITE_RESP, 2'b00, BRESP returned for every write (OKAY or SLVERR)
- S_AXI_ACLK in 1: the only clock
- S_AXI_ARESET in 1: synchronous, active-high reset
- S_AXI_AR{ID,ADDR,LEN,SIZE,BURST,VALID} in: AXI4 read address; SIZE/BURST ignored
- S_AXI_ARREADY out 1
- S_AXI_R{ID,DATA,RESP,LAST,VALID} out; S_AXI_RREADY in
- S_AXI_AW{ID,ADDR,LEN,VALID} in; S_AXI_AWREADY out 1
- S_AXI_W{DATA,STRB,LAST,VALID} in; S_AXI_WREADY out 1
- S_AXI_B{ID,RESP,VALID} out; S_AXI_BREADY in
- request_notification_{addr,id,offset,valid} out CHANNEL_ADDR_WIDTH/ID/log2(BEATS)/1
- availability_notification_{addr,id,offset,data,valid} in: same widths, data C_BRAM_DATA_WIDTH
- monitor_bypass_ready in 1: monitor-bypass can accept a request
- overflow_err, orphan_err, id_mismatch_err out 1: sticky error flags, cleared only by reset

## Operation
- AR acceptance: S_AXI_ARREADY = monitor_bypass_ready & !req_fifo_full & !S_AXI_ARESET (combinational). On handshake:
  - push {ARID, ARLEN} into the pending-request FIFO.
  - drive request_notification_valid=1 in the same cycle, with addr=ARADDR[CHANNEL_ADDR_WIDTH+5:6], offset=ARADDR[log2(BUS_BYTES)+:log2(BEATS)], id=ARID.
- Availability notifications are pushed into the line-data FIFO.
  - Push while that FIFO is full: the notification is dropped and overflow_err is set.
  - Push when the data-FIFO count ≥ the pending-request count: orphan_err is set, and the notification is still stored if space allows.
- Read FSM R_IDLE → R_BURST:
  - Leaves R_IDLE when both FIFOs are non-empty. It latches beat=0 and len=head ARLEN, and asserts RVALID on the next cycle.
  - Beat k returns word w=(offset+k) mod BEATS, where word w = data[(BEATS-1-w)*DW +: DW].
  - RID = request head ID. If the data head ID ≠ request head ID, id_mismatch_err is set and the burst is still returned.
  - RRESP=OKAY. RLAST is asserted on beat k=len. ARLEN ≥ BEATS keeps wrapping modulo BEATS; the beat counter is 8 bits.
  - RDATA, RID and RLAST stay stable while RVALID & !RREADY.
  - On the RLAST handshake, both FIFOs pop together and the FSM returns to R_IDLE.
- Write FSM W_IDLE → W_DATA → W_RESP:
  - AWREADY=1 only in W_IDLE; AW handshake latches AWID.
  - WREADY=1 only in W_DATA; write data is discarded.
  - The WLAST handshake moves the FSM to W_RESP with BVALID=1, BID=latched AWID, BRESP=WRITE_RESP. BVALID holds until BREADY, then the FSM returns to W_IDLE.
- A push and a pop on the same FIFO in the same cycle are both honoured, and the count is unchanged. Push-while-full is checked before the same-cycle pop, so it still counts as overflow.

## Timing
- Reset values: ARREADY 0 during reset; RVALID, RLAST, BVALID, AWREADY, WREADY, all error flags and request_notification_valid 0; RID, RDATA, BID, BRESP 0; both FSMs idle; both FIFOs empty.
- Reset asserted mid-burst aborts it on the next edge: RVALID=0, FIFOs flushed, no partial completion.
- Latency, availability push to first RVALID: 2 cycles (the FIFO write cycle, then the R_IDLE decision cycle). One idle cycle follows every burst before the next burst starts.
- A BEATS-beat burst with RREADY held high takes BEATS consecutive cycles.
- Write: minimum 3 cycles from AW handshake to B handshake.

## Structure
- Package burst_trapper_pkg holds:
  - the r_state_t and w_state_t enums
  - RESP_OKAY / RESP_SLVERR constants
  - a function word_index(offset, k) returning the wrapped word index
- Sub-module trapper_fifo (sync FIFO: parameters DATA_SIZE and DEPTH; ports push, pop, din, dout, full, empty, count). It is instantiated twice: line data (width ID+CHANNEL_ADDR_WIDTH+log2(BEATS)+C_BRAM_DATA_WIDTH) and requests (width ID+8).

## Test plan
All scenarios use BEATS=4 and DW=128 unless stated.
- AR id=1, ARADDR=0x1020, ARLEN=3, then availability id=1, offset=2, data={A,B,C,D} → notification addr=0x40, offset=2. R beats C,D,A,B; RLAST on 4th beat; RID=1; first RVALID 2 cycles after the availability push.
- ARLEN=0 at offset 3 → single beat D with RLAST=1. ARLEN=7 at offset 0 → A,B,C,D,A,B,C,D.
- RREADY toggling 1,0,0,1 during a burst → RDATA/RLAST held across the stall; no beat skipped or repeated.
- monitor_bypass_ready=0 → ARREADY=0. 8 outstanding ARs with no availability → 9th stalled. Two back-to-back bursts → exactly one idle cycle between them.
- 9 availability pushes without any AR, QUEUE_LENGTH=8 → orphan_err=1 from the first push; overflow_err=1 on the 9th push; both flags stay set until reset.
- AW id=1, 4 W beats with BREADY=0 for 5 cycles → BVALID=1, BID=1, BRESP=WRITE_RESP held; AWREADY=0 until B handshake. Reset asserted mid-R-burst → RVALID=0 next cycle, FIFOs empty.
